de_pipeline_reg: RTL
====================

Name: de_pipeline_reg

Overview:
- Decode→Execute pipeline register of the RV32I core; sits directly downstream of the decode-stage forwarding/hazard logic.
- Latches the decoded instruction and forwarded operands into E, and turns hazard requests (load-use stall, unresolved branch target, E-stage flush) into bubbles.
- Its registered outputs (rdE, reg_writeE, mem_loadE) feed back into the decode hazard logic.
- Also watches for hazard livelock.

Parameters:
- MAX_BUBBLE, 8, consecutive bubble cycles after which deadlockE is raised (≥2).
- CNT_W, 4, width of the consecutive-bubble counter; must hold MAX_BUBBLE.

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-high reset
- stall  input  1  load-use hazard from decode; insert bubble
- cannot_calcpc  input  1  branch/jalr target not computable in D; insert bubble
- flushE  input  1  redirect from E/M (mispredict, jump); kill instruction entering E
- validD  input  1  D holds a real instruction
- pcD  input  32  PC of D instruction
- reg_data1D, reg_data2D  input  32  forwarded operands
- immD  input  32  sign-extended immediate
- rs1D, rs2D, rdD  input  5  register indices
- alu_ctrlD  input  4  ALU op
- alu_srcD  input  1  1 = immediate as operand B
- reg_writeD  input  1  writes rd
- mem_loadD  input  3  load type, 000 = none
- mem_writeD  input  2  store size, 00 = none
- validE, pcE, reg_data1E, reg_data2E, immE, rs1E, rs2E, rdE, alu_ctrlE, alu_srcE, reg_writeE, mem_loadE, mem_writeE  output  (same widths)  registered E-stage copies
- bubble_cntE  output  CNT_W  current consecutive-bubble count
- deadlockE  output  1  sticky; hazard persisted MAX_BUBBLE cycles

Behaviour:
- Reset (async, immediate): every output is 0. This is a NOP: validE=0, rdE=0, reg_writeE=0, mem_loadE=000, mem_writeE=00. bubble_cntE=0, deadlockE=0.
- One-cycle latency. Each rising edge, exactly one action applies, by priority:
  1. flushE=1 → kill: load NOP.
  2. stall|cannot_calcpc=1 → bubble: load NOP.
  3. otherwise → capture all D fields; validE=validD.
- NOP definition:
  - Zeroes validE, rdE, reg_writeE, mem_loadE, mem_writeE, so a NOP causes no forwarding or hazard match downstream.
  - pcE, operand and imm fields hold their previous values; they are don't-care but deterministic.
- validD=0 with no hazard: capture still occurs, but reg_writeE, mem_loadE and mem_writeE are forced to 0 and rdE to 0.
- Consecutive-bubble counter:
  - Increments on each bubble cycle (priority 2 only), saturating at 2^CNT_W−1.
  - Clears on any capture or flush.
- deadlockE:
  - Sets on the edge where the counter reaches MAX_BUBBLE.
  - Stays set until reset; flush does not clear it.
- Simultaneous events: flush with stall → kill; counter clears.
- Does not gate the PC or D registers; upstream holds D whenever stall|cannot_calcpc.

Optional Feature:
- Macro DE_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_bubbleE[31:0] and perf_flushE[31:0], counting bubble cycles and kill cycles since reset.
  - Both are 32-bit and wrap at 2^32.
  - Both reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset mid-run: assert reset asynchronously between edges with validE=1, rdE=7 → outputs 0 immediately, before the next edge.
- Capture: validD=1, rdD=5, reg_writeD=1, mem_loadD=010, pcD=0x100, no hazard → next cycle rdE=5, reg_writeE=1, mem_loadE=010, pcE=0x100, validE=1.
- Load-use bubble: stall=1 for one cycle with rdD=6 → validE=0, rdE=0, reg_writeE=0, bubble_cntE=1. Next cycle stall=0 → rdE=6 captured, bubble_cntE=0.
- Flush priority: flushE=1, stall=1, reg_writeD=1 → NOP loaded, bubble_cntE=0. With DE_PERF_CNT_EN, perf_flushE increments by 1 and perf_bubbleE is unchanged.
- Deadlock: cannot_calcpc=1 held 8 cycles (MAX_BUBBLE=8) → deadlockE=1 after the 8th edge. Then drop hazard and flush → deadlockE stays 1 and bubble_cntE=0.
- validD=0, reg_writeD=1, rdD=3, no hazard → reg_writeE=0, rdE=0, validE=0.

Source files
------------

// File: rtl/de_pipeline_reg.sv
// Decode->Execute pipeline register: captures D fields, turns kill/bubble requests into NOPs,
// and flags hazard livelock. Optional perf counters under `DE_PERF_CNT_EN.
module de_pipeline_reg #(
   parameter int MAX_BUBBLE = 8,
   parameter int CNT_W      = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             cannot_calcpc,
   input  logic             flushE,
   input  logic             validD,
   input  logic [31:0]      pcD,
   input  logic [31:0]      reg_data1D,
   input  logic [31:0]      reg_data2D,
   input  logic [31:0]      immD,
   input  logic [4:0]       rs1D,
   input  logic [4:0]       rs2D,
   input  logic [4:0]       rdD,
   input  logic [3:0]       alu_ctrlD,
   input  logic             alu_srcD,
   input  logic             reg_writeD,
   input  logic [2:0]       mem_loadD,
   input  logic [1:0]       mem_writeD,
   output logic             validE,
   output logic [31:0]      pcE,
   output logic [31:0]      reg_data1E,
   output logic [31:0]      reg_data2E,
   output logic [31:0]      immE,
   output logic [4:0]       rs1E,
   output logic [4:0]       rs2E,
   output logic [4:0]       rdE,
   output logic [3:0]       alu_ctrlE,
   output logic             alu_srcE,
   output logic             reg_writeE,
   output logic [2:0]       mem_loadE,
   output logic [1:0]       mem_writeE,
   output logic [CNT_W-1:0] bubble_cntE,
   output logic             deadlockE
`ifdef DE_PERF_CNT_EN
   ,
   output logic [31:0]      perf_bubbleE,
   output logic [31:0]      perf_flushE
`endif
);

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] data1;
      logic [31:0] data2;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [3:0]  alu_ctrl;
      logic        alu_src;
      logic        reg_write;
      logic [2:0]  mem_load;
      logic [1:0]  mem_write;
   } de_t;

   de_t              de_d, de_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             deadlock_d, deadlock_q;
   logic             kill, bubble;

   assign kill   = flushE;
   assign bubble = !flushE && (stall || cannot_calcpc);

   always_comb begin
      de_d       = de_q;
      cnt_d      = '0;
      deadlock_d = deadlock_q;
      if (!kill && !bubble) begin
         de_d.valid     = validD;
         de_d.pc        = pcD;
         de_d.data1     = reg_data1D;
         de_d.data2     = reg_data2D;
         de_d.imm       = immD;
         de_d.rs1       = rs1D;
         de_d.rs2       = rs2D;
         de_d.alu_ctrl  = alu_ctrlD;
         de_d.alu_src   = alu_srcD;
         // A non-valid slot must never match downstream forwarding/hazard compares.
         de_d.rd        = validD ? rdD        : 5'd0;
         de_d.reg_write = validD ? reg_writeD : 1'b0;
         de_d.mem_load  = validD ? mem_loadD  : 3'd0;
         de_d.mem_write = validD ? mem_writeD : 2'd0;
      end else begin
         de_d.valid     = 1'b0;
         de_d.rd        = 5'd0;
         de_d.reg_write = 1'b0;
         de_d.mem_load  = 3'd0;
         de_d.mem_write = 2'd0;
      end
      if (bubble)
         cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
      if (bubble && cnt_d == CNT_W'(MAX_BUBBLE))
         deadlock_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         de_q       <= '0;
         cnt_q      <= '0;
         deadlock_q <= 1'b0;
      end else begin
         de_q       <= de_d;
         cnt_q      <= cnt_d;
         deadlock_q <= deadlock_d;
      end
   end

`ifdef DE_PERF_CNT_EN
   logic [31:0] perf_bubble_d, perf_bubble_q;
   logic [31:0] perf_flush_d, perf_flush_q;

   always_comb begin
      perf_bubble_d = perf_bubble_q + {31'd0, bubble};
      perf_flush_d  = perf_flush_q + {31'd0, kill};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_bubble_q <= '0;
         perf_flush_q  <= '0;
      end else begin
         perf_bubble_q <= perf_bubble_d;
         perf_flush_q  <= perf_flush_d;
      end
   end

   assign perf_bubbleE = perf_bubble_q;
   assign perf_flushE  = perf_flush_q;
`endif

   assign validE      = de_q.valid;
   assign pcE         = de_q.pc;
   assign reg_data1E  = de_q.data1;
   assign reg_data2E  = de_q.data2;
   assign immE        = de_q.imm;
   assign rs1E        = de_q.rs1;
   assign rs2E        = de_q.rs2;
   assign rdE         = de_q.rd;
   assign alu_ctrlE   = de_q.alu_ctrl;
   assign alu_srcE    = de_q.alu_src;
   assign reg_writeE  = de_q.reg_write;
   assign mem_loadE   = de_q.mem_load;
   assign mem_writeE  = de_q.mem_write;
   assign bubble_cntE = cnt_q;
   assign deadlockE   = deadlock_q;

endmodule
